// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - MEM stage: data-memory handshake, store lane placement, load extension, MEM/WB register
module memory_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  dmem_mask_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] InstrM,
  input  logic [31:0] PC_M,
  input  logic        ValidM,
  input  logic        StallExt,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] InstrW,
  output logic [31:0] PC_W,
  output logic        ValidW,
  output logic        MisalignW
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        misalign;
  } wb_t;

  state_t      state_q, state_d;
  logic [31:0] buf_q, buf_d;
  wb_t         wb_q, wb_d;

  logic [2:0]  funct3;
  logic        memop, misalign, pending, advance;
  logic [31:0] load_word, lane, load_data;

  always_comb begin
    funct3   = InstrM[14:12];
    memop    = ValidM & (MemReadM | MemWriteM);
    misalign = memop & (((funct3[1:0] == 2'b01) & ALU_ResultM[0]) |
                        ((funct3[1:0] == 2'b10) & (ALU_ResultM[1:0] != 2'b00)));
    // Gating with rst keeps the request and stall quiet for the whole reset pulse.
    pending  = memop & ~misalign & (state_q != DONE) & rst;
    StallM   = pending & ~dmem_ack;
    advance  = ~StallM & ~StallExt;

    dmem_req   = pending;
    dmem_we    = MemWriteM;
    dmem_addr  = {ALU_ResultM[31:2], 2'b00};
    dmem_be    = dmem_mask_M;
    dmem_wdata = (funct3[1:0] == 2'b10) ? WriteDataM
                                        : (WriteDataM << {ALU_ResultM[1:0], 3'b000});

    load_word = (state_q == DONE) ? buf_q : dmem_rdata;
    lane      = load_word >> {ALU_ResultM[1:0], 3'b000};
    case (funct3)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'h0, lane[7:0]};
      3'b101:  load_data = {16'h0, lane[15:0]};
      default: load_data = load_word;
    endcase
    if (!(memop & MemReadM & ~misalign)) load_data = 32'h0;
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    // Ack under an external stall: park the data so the access is never repeated.
    if (pending & dmem_ack & StallExt) begin
      state_d = DONE;
      buf_d   = dmem_rdata;
    end else begin
      case (state_q)
        IDLE:    if (pending & ~dmem_ack) state_d = WAIT;
        WAIT:    if (dmem_ack & ~StallExt) state_d = IDLE;
        DONE:    if (~StallExt) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    wb_d = '0;
    if (advance) begin
      wb_d.reg_write  = RegWriteM & ~misalign;
      wb_d.result_src = ResultSrcM;
      wb_d.rd         = RD_M;
      wb_d.alu_result = ALU_ResultM;
      wb_d.read_data  = load_data;
      wb_d.pc_plus4   = PCPlus4M;
      wb_d.instr      = InstrM;
      wb_d.pc         = PC_M;
      wb_d.valid      = ValidM;
      wb_d.misalign   = misalign;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      wb_q    <= wb_d;
    end
  end

  assign RegWriteW   = wb_q.reg_write;
  assign ResultSrcW  = wb_q.result_src;
  assign RD_W        = wb_q.rd;
  assign ALU_ResultW = wb_q.alu_result;
  assign ReadDataW   = wb_q.read_data;
  assign PCPlus4W    = wb_q.pc_plus4;
  assign InstrW      = wb_q.instr;
  assign PC_W        = wb_q.pc;
  assign ValidW      = wb_q.valid;
  assign MisalignW   = wb_q.misalign;

endmodule

// File: tb/tb_memory_cycle.sv
// tb/tb_memory_cycle.sv - directed and randomized checks of memory_cycle against a transaction-level model
module tb_memory_cycle;
  logic clk = 1'b0;
  logic rst;
  logic RegWriteM, MemWriteM, MemReadM, ValidM, StallExt;
  logic [1:0] ResultSrcM;
  logic [4:0] RD_M;
  logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M, InstrM, PC_M;
  logic [3:0] dmem_mask_M;
  logic dmem_req, dmem_we, dmem_ack, StallM;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0] dmem_be;
  logic RegWriteW, ValidW, MisalignW;
  logic [1:0] ResultSrcW;
  logic [4:0] RD_W;
  logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W, InstrW, PC_W;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  memory_cycle dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .ResultSrcM(ResultSrcM), .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .dmem_mask_M(dmem_mask_M), .PCPlus4M(PCPlus4M), .InstrM(InstrM), .PC_M(PC_M), .ValidM(ValidM),
    .StallExt(StallExt), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .InstrW(InstrW),
    .PC_W(PC_W), .ValidW(ValidW), .MisalignW(MisalignW)
  );

  function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] w);
    logic [31:0] sh;
    logic [31:0] b;
    logic [31:0] h;
    sh = w >> ((addr % 4) * 8);
    b  = sh % 256;
    h  = sh % 65536;
    case (f3)
      3'd0: return (b >= 128) ? (32'hFFFFFF00 | b) : b;
      3'd1: return (h >= 32768) ? (32'hFFFF0000 | h) : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] wdata_model(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
    if (f3 % 4 == 2) return d;
    return d << ((addr % 4) * 8);
  endfunction

  function automatic logic mis_model(input logic mop, input logic [2:0] f3, input logic [31:0] addr);
    return mop && (((f3 % 4 == 1) && (addr % 2 != 0)) || ((f3 % 4 == 2) && (addr % 4 != 0)));
  endfunction

  task automatic set_instr(input logic v, input logic rw, input logic rd_en, input logic wr_en,
                           input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] mask);
    logic [31:0] ins;
    ins = $urandom;
    ins[14:12] = f3;
    ValidM = v; RegWriteM = rw; MemReadM = rd_en; MemWriteM = wr_en;
    InstrM = ins; ALU_ResultM = addr; WriteDataM = wd; dmem_mask_M = mask;
    ResultSrcM = 2'($urandom); RD_M = 5'($urandom);
    PCPlus4M = $urandom; PC_M = $urandom;
  endtask

  task automatic idle();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 4'h0);
    dmem_ack = 1'b0; StallExt = 1'b0; dmem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_instr(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 4'hF);
    dmem_ack = 1'b0; StallExt = 1'b0; dmem_rdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", dmem_req); end
    total++; if (StallM !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", StallM); end
    total++;
    if ({RegWriteW, ResultSrcW, RD_W, ALU_ResultW, ReadDataW, PCPlus4W, InstrW, PC_W, ValidW, MisalignW} !== '0) begin
      bad++; $display("FAIL reset_wb got valid=%b alu=%h pc=%h instr=%h want all zero", ValidW, ALU_ResultW, PC_W, InstrW);
    end
    idle();
    #2 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_load();
    set_instr(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 4'hF);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    total++; if (StallM !== 1'b0) begin bad++; $display("FAIL single_stall got=%b want=0", StallM); end
    total++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100) begin bad++; $display("FAIL single_req got=%b/%h want=1/00000100", dmem_req, dmem_addr); end
    @(posedge clk); #1;
    total++; if (ValidW !== 1'b1 || ReadDataW !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wb got=%b/%h want=1/deadbeef", ValidW, ReadDataW); end
    idle();
  endtask

  task automatic test_waited_store();
    int writes = 0;
    set_instr(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h203, 32'h0000_00A5, 4'b1000);
    for (int c = 0; c < 4; c++) begin
      dmem_ack = (c == 3);
      #1;
      total++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b1000 || dmem_wdata !== 32'hA500_0000 || dmem_addr !== 32'h200) begin
        bad++; $display("FAIL store_bus c=%0d got req=%b we=%b be=%b wd=%h a=%h want 1 1 1000 a5000000 00000200", c, dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr);
      end
      total++; if (StallM !== (c < 3)) begin bad++; $display("FAIL store_stall c=%0d got=%b want=%b", c, StallM, c < 3); end
      if (dmem_req && dmem_we && dmem_ack) writes++;
      @(posedge clk); #1;
      total++; if (ValidW !== (c == 3)) begin bad++; $display("FAIL store_wb c=%0d got valid=%b want=%b", c, ValidW, c == 3); end
    end
    total++; if (writes !== 1) begin bad++; $display("FAIL store_count got=%0d want=1", writes); end
    idle();
  endtask

  task automatic test_load_ext();
    logic [31:0] want;
    for (int k = 0; k < 2; k++) begin
      set_instr(1'b1, 1'b1, 1'b1, 1'b0, (k == 0) ? 3'd0 : 3'd4, 32'h102, 32'h0, 4'b0100);
      dmem_ack = 1'b1; dmem_rdata = 32'h0080FF00;
      want = (k == 0) ? 32'hFFFFFF80 : 32'h00000080;
      @(posedge clk); #1;
      total++; if (ReadDataW !== want) begin bad++; $display("FAIL load_ext k=%0d got=%h want=%h", k, ReadDataW, want); end
    end
    idle();
  endtask

  task automatic test_ack_during_stall();
    set_instr(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 32'h006, 32'h0, 4'b1100);
    StallExt = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h8001_1234;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin dmem_ack = 1'b0; dmem_rdata = 32'h1234_5678; end
      if (c == 3) StallExt = 1'b0;
      #1;
      total++; if (dmem_req !== (c == 0)) begin bad++; $display("FAIL extstall_req c=%0d got=%b want=%b", c, dmem_req, c == 0); end
      total++; if (StallM !== 1'b0) begin bad++; $display("FAIL extstall_stall c=%0d got=%b want=0", c, StallM); end
      @(posedge clk); #1;
      total++; if (ValidW !== (c == 3)) begin bad++; $display("FAIL extstall_valid c=%0d got=%b want=%b", c, ValidW, c == 3); end
    end
    total++; if (ReadDataW !== 32'hFFFF8001) begin bad++; $display("FAIL extstall_data got=%h want=ffff8001", ReadDataW); end
    idle();
  endtask

  task automatic test_misaligned();
    set_instr(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 4'hF);
    #1;
    total++; if (dmem_req !== 1'b0 || StallM !== 1'b0) begin bad++; $display("FAIL misalign_req got req=%b stall=%b want 0 0", dmem_req, StallM); end
    @(posedge clk); #1;
    total++; if ({MisalignW, ValidW, RegWriteW} !== 3'b110) begin bad++; $display("FAIL misalign_wb got mis/valid/rw=%b%b%b want 110", MisalignW, ValidW, RegWriteW); end
    idle();
  endtask

  task automatic test_reset_during_wait();
    set_instr(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 4'hF);
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    total++; if (StallM !== 1'b1 || dmem_req !== 1'b1) begin bad++; $display("FAIL rstwait_pre got stall=%b req=%b want 1 1", StallM, dmem_req); end
    #1 rst = 1'b0;
    #1;
    total++; if (dmem_req !== 1'b0 || StallM !== 1'b0) begin bad++; $display("FAIL rstwait_drop got req=%b stall=%b want 0 0", dmem_req, StallM); end
    total++; if ({ValidW, RegWriteW, ReadDataW, ALU_ResultW, PC_W} !== '0) begin bad++; $display("FAIL rstwait_wb got valid=%b alu=%h want zeros", ValidW, ALU_ResultW); end
    idle();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    total++; if (dmem_req !== 1'b0 || ValidW !== 1'b0) begin bad++; $display("FAIL rstwait_after got req=%b valid=%b want 0 0", dmem_req, ValidW); end
    set_instr(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 4'hF);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    #1;
    total++; if (dmem_req !== 1'b1 || StallM !== 1'b0) begin bad++; $display("FAIL rstwait_idle got req=%b stall=%b want 1 0", dmem_req, StallM); end
    @(posedge clk); #1;
    total++; if (ValidW !== 1'b1 || ReadDataW !== 32'hCAFEF00D) begin bad++; $display("FAIL rstwait_new got %b/%h want 1/cafef00d", ValidW, ReadDataW); end
    idle();
  endtask

  task automatic test_random();
    logic [2:0] loads [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int n = 0; n < 150; n++) begin
      int kind, lat, waited, cyc;
      logic v, mop, mis, done, exp_req, exp_adv, got, is_load;
      logic [2:0] f3;
      logic [31:0] addr, word;
      logic [137:0] exp_wb;
      kind = $urandom % 3;
      v = ($urandom % 8) != 0;
      f3 = (kind == 1) ? loads[$urandom % 5] : 3'($urandom % 3);
      addr = $urandom;
      set_instr(v, 1'($urandom), kind == 1, kind == 2, f3, addr, $urandom, 4'($urandom));
      mop = v && (kind != 0);
      mis = mis_model(mop, f3, addr);
      is_load = mop && (kind == 1) && !mis;
      lat = $urandom % 4;
      waited = 0; done = 0; got = 0; cyc = 0; word = 32'h0;
      while (!got && cyc < 40) begin
        StallExt = ($urandom % 3) == 0;
        exp_req = mop && !mis && !done;
        dmem_ack = exp_req && (waited >= lat);
        dmem_rdata = $urandom;
        #1;
        total++; if (dmem_req !== exp_req) begin bad++; $display("FAIL rnd_req n=%0d got=%b want=%b", n, dmem_req, exp_req); end
        total++; if (StallM !== (exp_req && !dmem_ack)) begin bad++; $display("FAIL rnd_stall n=%0d got=%b want=%b", n, StallM, exp_req && !dmem_ack); end
        if (exp_req) begin
          total++;
          if (dmem_we !== (kind == 2) || dmem_addr !== {addr[31:2], 2'b00} || dmem_be !== dmem_mask_M ||
              (kind == 2 && dmem_wdata !== wdata_model(f3, addr, WriteDataM))) begin
            bad++; $display("FAIL rnd_bus n=%0d got we=%b a=%h be=%b wd=%h want %b %h %b %h", n, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                            kind == 2, {addr[31:2], 2'b00}, dmem_mask_M, wdata_model(f3, addr, WriteDataM));
          end
        end
        exp_adv = !(exp_req && !dmem_ack) && !StallExt;
        if (exp_req && dmem_ack) word = dmem_rdata;
        if (exp_req && dmem_ack && !exp_adv) done = 1'b1;
        if (exp_req) waited++;
        exp_wb = exp_adv ? {RegWriteM && !mis, ResultSrcM, RD_M, ALU_ResultM, PCPlus4M, InstrM, PC_M, ValidM, mis} : '0;
        @(posedge clk); #1;
        total++;
        if ({RegWriteW, ResultSrcW, RD_W, ALU_ResultW, PCPlus4W, InstrW, PC_W, ValidW, MisalignW} !== exp_wb) begin
          bad++; $display("FAIL rnd_wb n=%0d got=%h want=%h", n, {RegWriteW, ResultSrcW, RD_W, ALU_ResultW, PCPlus4W, InstrW, PC_W, ValidW, MisalignW}, exp_wb);
        end
        if (!mis) begin
          total++;
          if (ReadDataW !== ((exp_adv && is_load) ? ext_model(f3, addr, word) : 32'h0)) begin
            bad++; $display("FAIL rnd_rdata n=%0d got=%h want=%h", n, ReadDataW, (exp_adv && is_load) ? ext_model(f3, addr, word) : 32'h0);
          end
        end
        got = exp_adv;
        cyc++;
      end
      total++; if (!got) begin bad++; $display("FAIL rnd_timeout n=%0d got=no advance want=advance", n); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_waited_store();
    test_load_ext();
    test_ack_during_stall();
    test_misaligned();
    test_reset_during_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
